dvbs2x_tx_symb_rate_switch_ctrl: RTL and testbench
==================================================

// Module: dvbs2x_tx_symb_rate_switch_ctrl
//
// PURPOSE
// Sequences run-time symbol-rate changes of the TX symbol-rate divider.
// Accepts a rate-change request and closes the sample-stream handshake between modulator and divider.
// Drains the interpolation FIR pipeline, updates symb_rate_sel, waits for the new FIR path to fill, then reopens the stream.
// Mutes the DAC path while the stream is closed, so partial filter output never reaches the DAC.
// Sits between dvbs2x_tx and dvbs2x_tx_symb_rate_divider_core; sample data bypasses this block, only handshake lines pass through it.
//
// PARAMETERS
// DEFAULT_SYMB_RATE_SEL  TX_SYMB_RATE_FULL  rate driven on symb_rate_sel out of reset (DVBS2X_TX_SYMB_RATE_DIVIDER_PKG)
// DRAIN_CYCLES           64                 cycles in DRAIN; >= FIR latency; elab check >= 1
// SETTLE_CYCLES          64                 cycles in SETTLE; >= FIR group delay; elab check >= 1
// CNT_NB                 16                 phase counter width; elab check 2**CNT_NB > max(DRAIN_CYCLES, SETTLE_CYCLES)
//
// PORTS
// clk_sample          in   1                 sample clock; the only clock
// aresetn_sample      in   1                 asynchronous active-low reset
// req_valid           in   1                 rate-change request valid
// req_ready           out  1                 request accepted when req_valid & req_ready
// req_symb_rate_sel   in   SYMB_RATE_SEL_NB  requested rate; values >= NUM_TX_SYMB_RATES are invalid
// up_tvalid           in   1                 modulator tvalid
// up_tready           out  1                 tready returned to modulator
// core_tvalid         out  1                 tvalid to divider core
// core_tready         in   1                 tready from divider core
// symb_rate_sel       out  SYMB_RATE_SEL_NB  registered select to divider core
// dac_mute            out  1                 1 = downstream forces samples to zero
// busy                out  1                 1 whenever state != RUN
// switch_count        out  8                 completed switches; wraps 255 -> 0
// err_invalid_sel     out  1                 sticky; set by an accepted invalid request
// err_clear           in   1                 clears err_invalid_sel
//
// BEHAVIOUR
// - Reset (async assert, sync deassert internally): state=RUN, symb_rate_sel=DEFAULT_SYMB_RATE_SEL, dac_mute=0, busy=0, switch_count=0, err_invalid_sel=0.
// - States:
//   - RUN: gate open; core_tvalid=up_tvalid, up_tready=core_tready (combinational); req_ready=1.
//   - DRAIN: gate closed; core_tvalid=0, up_tready=0, req_ready=0, dac_mute=1; lasts exactly DRAIN_CYCLES cycles.
//   - SWITCH: gate closed, dac_mute=1; 1 cycle; symb_rate_sel <= latched request, visible from the next cycle.
//   - SETTLE: gate closed, dac_mute=1; lasts exactly SETTLE_CYCLES cycles; on exit switch_count increments and state goes to RUN.
// - Acceptance at cycle T in RUN, for a valid request different from the current rate:
//   - The request value is latched.
//   - A beat handshaken at cycle T still passes.
//   - From T+1 the state is DRAIN.
//   - RUN resumes at T+1+DRAIN_CYCLES+1+SETTLE_CYCLES.
// - Request equal to the current symb_rate_sel: accepted, no state change, no mute, switch_count unchanged.
// - Invalid request (>= NUM_TX_SYMB_RATES): accepted and discarded; err_invalid_sel=1 from T+1; no state change.
// - Requests are never queued: req_ready=0 outside RUN. The requester holds req_valid and it is accepted on the first RUN cycle.
// - err_clear and a new invalid request in the same cycle: set wins.
// - The phase counter loads at phase entry and counts down to 0; no other counter runs.
// - busy and dac_mute are registered, asserted from T+1 to the last SETTLE cycle inclusive.
// - Reset mid-switch: returns to RUN with the DEFAULT select. The pending request is lost and switch_count is cleared.
// - Upstream AXIS rules hold: in RUN, valid and ready are passed through unmodified.
//
// TESTING
// - Reset: DEFAULT=FULL; after release -> symb_rate_sel=2, busy=0, req_ready=1, up_tready follows core_tready.
// - Request HALF at T, DRAIN=SETTLE=4:
//   - gate closed and dac_mute=1 over T+1..T+9.
//   - symb_rate_sel=1 from T+6; busy=0 and gate open at T+10; switch_count=1.
// - Request FULL while already FULL -> accepted in 1 cycle; busy stays 0; switch_count unchanged.
// - Request 3 -> err_invalid_sel=1, sel unchanged. err_clear with a simultaneous req 3 -> stays 1. err_clear alone -> 0.
// - req_valid held with QUARTER during SETTLE -> req_ready=0 until RUN, then accepted on the first RUN cycle; second switch completes, switch_count=2.
// - Assert reset during DRAIN: outputs return to reset values immediately. 256 back-to-back switches -> switch_count wraps to 0.

Source files
------------

// File: rtl/dvbs2x_tx_symb_rate_switch_ctrl.sv
// Run-time symbol-rate switch sequencer: closes the sample handshake,
// drains the FIR, swaps symb_rate_sel, waits for settle, then reopens.
package dvbs2x_tx_symb_rate_divider_pkg;
    localparam int SYMB_RATE_SEL_NB  = 2;
    localparam int NUM_TX_SYMB_RATES = 3;
    localparam logic [SYMB_RATE_SEL_NB-1:0] TX_SYMB_RATE_QUARTER = 2'd0;
    localparam logic [SYMB_RATE_SEL_NB-1:0] TX_SYMB_RATE_HALF    = 2'd1;
    localparam logic [SYMB_RATE_SEL_NB-1:0] TX_SYMB_RATE_FULL    = 2'd2;
endpackage

module dvbs2x_tx_symb_rate_switch_ctrl
    import dvbs2x_tx_symb_rate_divider_pkg::*;
#(
    parameter logic [SYMB_RATE_SEL_NB-1:0] DEFAULT_SYMB_RATE_SEL = TX_SYMB_RATE_FULL,
    parameter int DRAIN_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_NB        = 16
) (
    input  logic                        clk_sample,
    input  logic                        aresetn_sample,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [SYMB_RATE_SEL_NB-1:0] req_symb_rate_sel,
    input  logic                        up_tvalid,
    output logic                        up_tready,
    output logic                        core_tvalid,
    input  logic                        core_tready,
    output logic [SYMB_RATE_SEL_NB-1:0] symb_rate_sel,
    output logic                        dac_mute,
    output logic                        busy,
    output logic [7:0]                  switch_count,
    output logic                        err_invalid_sel,
    input  logic                        err_clear
);

    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $fatal(1, "DRAIN_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $fatal(1, "SETTLE_CYCLES must be >= 1");
    end
    if ((64'(1) << CNT_NB) <= 64'(DRAIN_CYCLES) ||
        (64'(1) << CNT_NB) <= 64'(SETTLE_CYCLES)) begin : g_bad_cnt
        $fatal(1, "CNT_NB too narrow for phase lengths");
    end

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_SWITCH,
        S_SETTLE
    } state_t;

    state_t                      state;
    logic [CNT_NB-1:0]           cnt;
    logic [SYMB_RATE_SEL_NB-1:0] pend_sel;
    logic [1:0]                  rst_sync;
    logic                        rst_n;
    logic                        run;
    logic                        req_acc;
    logic                        req_bad;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_sample or negedge aresetn_sample) begin
        if (!aresetn_sample) rst_sync <= 2'b00;
        else                 rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign run         = (state == S_RUN);
    assign req_ready   = run & rst_n;
    assign req_acc     = req_valid & req_ready;
    assign req_bad     = int'(req_symb_rate_sel) >= NUM_TX_SYMB_RATES;
    assign core_tvalid = run & up_tvalid;
    assign up_tready   = run & core_tready;

    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RUN;
            cnt             <= '0;
            pend_sel        <= DEFAULT_SYMB_RATE_SEL;
            symb_rate_sel   <= DEFAULT_SYMB_RATE_SEL;
            dac_mute        <= 1'b0;
            busy            <= 1'b0;
            switch_count    <= 8'd0;
            err_invalid_sel <= 1'b0;
        end else begin
            if (req_acc && req_bad)  err_invalid_sel <= 1'b1;
            else if (err_clear)      err_invalid_sel <= 1'b0;

            unique case (state)
                S_RUN: begin
                    if (req_acc && !req_bad &&
                        req_symb_rate_sel != symb_rate_sel) begin
                        pend_sel <= req_symb_rate_sel;
                        cnt      <= CNT_NB'(DRAIN_CYCLES - 1);
                        state    <= S_DRAIN;
                        busy     <= 1'b1;
                        dac_mute <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) state <= S_SWITCH;
                    else           cnt   <= cnt - 1'b1;
                end
                S_SWITCH: begin
                    symb_rate_sel <= pend_sel;
                    cnt           <= CNT_NB'(SETTLE_CYCLES - 1);
                    state         <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state        <= S_RUN;
                        busy         <= 1'b0;
                        dac_mute     <= 1'b0;
                        switch_count <= switch_count + 8'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dvbs2x_tx_symb_rate_switch_ctrl.sv
// Bench for the symbol-rate switch sequencer: directed scenarios plus
// random traffic against a cycle-timestamp reference model.
module tb_dvbs2x_tx_symb_rate_switch_ctrl;

    localparam int D = 4;
    localparam int S = 4;

    logic       clk_sample = 1'b0;
    logic       aresetn_sample;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_symb_rate_sel;
    logic       up_tvalid;
    logic       up_tready;
    logic       core_tvalid;
    logic       core_tready;
    logic [1:0] symb_rate_sel;
    logic       dac_mute;
    logic       busy;
    logic [7:0] switch_count;
    logic       err_invalid_sel;
    logic       err_clear;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: absolute cycle stamps of the pending switch
    int         cyc;
    int         run_at;
    int         sel_at;
    logic [1:0] m_sel;
    logic [1:0] m_pend;
    logic [7:0] m_cnt;
    logic       m_err;

    always #5 clk_sample = ~clk_sample;

    dvbs2x_tx_symb_rate_switch_ctrl #(
        .DRAIN_CYCLES (D),
        .SETTLE_CYCLES(S),
        .CNT_NB       (4)
    ) dut (
        .clk_sample       (clk_sample),
        .aresetn_sample   (aresetn_sample),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_symb_rate_sel(req_symb_rate_sel),
        .up_tvalid        (up_tvalid),
        .up_tready        (up_tready),
        .core_tvalid      (core_tvalid),
        .core_tready      (core_tready),
        .symb_rate_sel    (symb_rate_sel),
        .dac_mute         (dac_mute),
        .busy             (busy),
        .switch_count     (switch_count),
        .err_invalid_sel  (err_invalid_sel),
        .err_clear        (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        run_at = -1;
        sel_at = -1;
        m_sel  = 2'd2;
        m_pend = 2'd2;
        m_cnt  = 8'd0;
        m_err  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   32'(symb_rate_sel), 32'd2);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_mute"},  32'(dac_mute), 32'd0);
        chk({tag, "_cnt"},   32'(switch_count), 32'd0);
        chk({tag, "_err"},   32'(err_invalid_sel), 32'd0);
    endtask

    task automatic do_reset();
        aresetn_sample = 1'b0;
        req_valid      = 1'b0;
        err_clear      = 1'b0;
        #1;
        chk_reset_vals("rst_now");
        @(posedge clk_sample);
        #1;
        aresetn_sample = 1'b1;
        repeat (3) @(posedge clk_sample);
        #1;
        model_reset();
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic cycle(input logic rv, input logic [1:0] rs,
                         input logic ec);
        logic bsy;
        logic acc;
        req_valid         = rv;
        req_symb_rate_sel = rs;
        err_clear         = ec;
        up_tvalid         = 1'($urandom);
        core_tready       = 1'($urandom);
        @(negedge clk_sample);
        bsy = (cyc < run_at);
        chk("busy",        32'(busy), 32'(bsy));
        chk("dac_mute",    32'(dac_mute), 32'(bsy));
        chk("req_ready",   32'(req_ready), 32'(!bsy));
        chk("up_tready",   32'(up_tready), 32'(core_tready & !bsy));
        chk("core_tvalid", 32'(core_tvalid), 32'(up_tvalid & !bsy));
        chk("sel",         32'(symb_rate_sel), 32'(m_sel));
        chk("switch_cnt",  32'(switch_count), 32'(m_cnt));
        chk("err",         32'(err_invalid_sel), 32'(m_err));
        @(posedge clk_sample);
        acc = rv && !bsy;
        if (acc && rs >= 2'd3) m_err = 1'b1;
        else if (ec)           m_err = 1'b0;
        if (acc && rs < 2'd3 && rs != m_sel) begin
            m_pend = rs;
            sel_at = cyc + D + 2;
            run_at = cyc + 1 + D + 1 + S;
        end
        cyc++;
        if (cyc == sel_at) m_sel = m_pend;
        if (cyc == run_at) m_cnt = m_cnt + 8'd1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        cyc               = 0;
        aresetn_sample    = 1'b0;
        req_valid         = 1'b0;
        req_symb_rate_sel = 2'd0;
        up_tvalid         = 1'b0;
        core_tready       = 1'b0;
        err_clear         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_sample);
        #1;
        chk_reset_vals("rst");
        aresetn_sample = 1'b1;
        repeat (3) @(posedge clk_sample);
        #1;

        idle(2);
        cycle(1'b1, 2'd1, 1'b0);
        idle(12);
        cycle(1'b1, 2'd1, 1'b0);
        idle(2);
        cycle(1'b1, 2'd3, 1'b0);
        idle(2);
        cycle(1'b1, 2'd3, 1'b1);
        idle(1);
        cycle(1'b0, 2'd0, 1'b1);
        idle(1);

        cycle(1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 2'd0, 1'b0);
        idle(12);

        cycle(1'b1, 2'd1, 1'b0);
        idle(2);
        do_reset();
        idle(3);

        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b0);
            idle(D + S + 1);
        end
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) == 0), 2'($urandom),
                  ($urandom_range(0, 7) == 0));
            if (i == 1500) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
